wdt_multi: RTL and testbench

Multi-channel watchdog timer for the core bench and SoC top: a parametrised successor to the single free-running watchdog counter. It provides NUM_CH independent channels, each with a programmable timeout, an early-warning threshold, one-shot or auto-reload mode, and a sticky expiry flag. An aggregate `any_expired` output drives the simulation-stop or core-halt logic.

---
 rtl/wdt_multi.sv | 157 +++++++++++++++
 tb/tb_wdt_multi.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdt_multi.sv
// wdt_multi: NUM_CH independent watchdog channels with timeout, early warning, reload and sticky expiry.
// Build option WDT_WINDOW_EN adds the window_open port, and an early kick then counts as a violation.

module wdt_ch #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             kick,
   input  logic             ack,
   input  logic             auto_reload,
   input  logic [CNT_W-1:0] timeout,
   input  logic [CNT_W-1:0] warn_thresh,
   input  logic [CNT_W-1:0] open_at,
   output logic [CNT_W-1:0] count,
   output logic             warn,
   output logic             expired,
   output logic             expire_pulse,
   output logic             violation
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXPIRED} state_t;

   state_t           state;
   logic [CNT_W-1:0] t_lat, w_lat, o_lat, cnt_inc;
   logic             at_limit, early, warn_on;

   // count never exceeds t_lat, so cnt_inc cannot wrap while running
   assign cnt_inc  = count + 1'b1;
   assign at_limit = (t_lat != '0) && (cnt_inc == t_lat);
   assign early    = count < o_lat;
   assign warn_on  = (w_lat != '0) && (w_lat < t_lat) && (cnt_inc >= w_lat);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         count        <= '0;
         t_lat        <= '0;
         w_lat        <= '0;
         o_lat        <= '0;
         warn         <= 1'b0;
         expired      <= 1'b0;
         expire_pulse <= 1'b0;
         violation    <= 1'b0;
      end else begin
         warn         <= 1'b0;
         expire_pulse <= 1'b0;
         violation    <= 1'b0;
         // a set later in this block overrides this clear
         if (ack) expired <= 1'b0;
         if (!en) begin
            state <= S_IDLE;
            count <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  state <= S_RUN;
                  count <= '0;
                  t_lat <= timeout;
                  w_lat <= warn_thresh;
                  o_lat <= open_at;
               end
               S_RUN: begin
                  if (kick && !early) begin
                     count <= '0;
                     t_lat <= timeout;
                     w_lat <= warn_thresh;
                     o_lat <= open_at;
                  end else if (kick || at_limit) begin
                     // early kick behaves exactly like a timeout, plus the violation pulse
                     expire_pulse <= 1'b1;
                     expired      <= 1'b1;
                     violation    <= kick;
                     if (auto_reload) begin
                        count <= '0;
                        t_lat <= timeout;
                        w_lat <= warn_thresh;
                        o_lat <= open_at;
                     end else begin
                        state <= S_EXPIRED;
                        count <= t_lat;
                     end
                  end else if (t_lat != '0) begin
                     count <= cnt_inc;
                     warn  <= warn_on;
                  end
               end
               S_EXPIRED: begin
                  if (ack) begin
                     state <= S_RUN;
                     count <= '0;
                     t_lat <= timeout;
                     w_lat <= warn_thresh;
                     o_lat <= open_at;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

module wdt_multi #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH-1:0]       kick,
   input  logic [NUM_CH-1:0]       ack,
   input  logic [NUM_CH-1:0]       auto_reload,
   input  logic [NUM_CH*CNT_W-1:0] timeout,
   input  logic [NUM_CH*CNT_W-1:0] warn_thresh,
`ifdef WDT_WINDOW_EN
   input  logic [NUM_CH*CNT_W-1:0] window_open,
`endif
   output logic [NUM_CH*CNT_W-1:0] count,
   output logic [NUM_CH-1:0]       warn,
   output logic [NUM_CH-1:0]       expired,
   output logic [NUM_CH-1:0]       expire_pulse,
   output logic [NUM_CH-1:0]       violation,
   output logic                    any_expired
);
   genvar i;
   for (i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] open_at;
`ifdef WDT_WINDOW_EN
      assign open_at = window_open[i*CNT_W +: CNT_W];
`else
      // zero window accepts every kick, so violation stays constant 0
      assign open_at = '0;
`endif
      wdt_ch #(.CNT_W(CNT_W)) u_ch (
         .clk          (clk),
         .rst          (rst),
         .en           (en[i]),
         .kick         (kick[i]),
         .ack          (ack[i]),
         .auto_reload  (auto_reload[i]),
         .timeout      (timeout[i*CNT_W +: CNT_W]),
         .warn_thresh  (warn_thresh[i*CNT_W +: CNT_W]),
         .open_at      (open_at),
         .count        (count[i*CNT_W +: CNT_W]),
         .warn         (warn[i]),
         .expired      (expired[i]),
         .expire_pulse (expire_pulse[i]),
         .violation    (violation[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) any_expired <= 1'b0;
      else     any_expired <= |expired;
   end
endmodule

// File: tb/tb_wdt_multi.sv
// Scoreboard bench for wdt_multi: stimulus queues hand-derived expectations per clock edge,
// a negedge monitor pops and compares them. Window checks run only when WDT_WINDOW_EN is defined.
`timescale 1ns/1ps
module tb_wdt_multi;
   localparam int NUM_CH = 2;
   localparam int CNT_W  = 16;
   localparam int F_CNT = 0, F_WARN = 1, F_EXP = 2, F_PUL = 3, F_VIO = 4, F_ANY = 5;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH-1:0]       en, kick, ack, auto_reload;
   logic [NUM_CH*CNT_W-1:0] timeout, warn_thresh;
`ifdef WDT_WINDOW_EN
   logic [NUM_CH*CNT_W-1:0] window_open;
`endif
   logic [NUM_CH*CNT_W-1:0] count;
   logic [NUM_CH-1:0]       warn, expired, expire_pulse, violation;
   logic                    any_expired;

   typedef struct {
      int    edge_n;
      string name;
      int    fld;
      int    ch;
      int    val;
   } exp_t;

   exp_t        q[$];
   exp_t        cur;
   logic [31:0] act;
   int          edge_n = 0;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   wdt_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .kick         (kick),
      .ack          (ack),
      .auto_reload  (auto_reload),
      .timeout      (timeout),
      .warn_thresh  (warn_thresh),
`ifdef WDT_WINDOW_EN
      .window_open  (window_open),
`endif
      .count        (count),
      .warn         (warn),
      .expired      (expired),
      .expire_pulse (expire_pulse),
      .violation    (violation),
      .any_expired  (any_expired)
   );

   function automatic logic [31:0] actual(int fld, int ch);
      case (fld)
         F_CNT:   return {16'b0, count[ch*CNT_W +: CNT_W]};
         F_WARN:  return {31'b0, warn[ch]};
         F_EXP:   return {31'b0, expired[ch]};
         F_PUL:   return {31'b0, expire_pulse[ch]};
         F_VIO:   return {31'b0, violation[ch]};
         default: return {31'b0, any_expired};
      endcase
   endfunction

   // monitor: compare every expectation queued for the most recent edge
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].edge_n <= edge_n) begin
         cur = q.pop_front();
         act = actual(cur.fld, cur.ch);
         vectors++;
         if (cur.edge_n != edge_n || act !== cur.val) begin
            miscompares++;
            $display("FAIL %s (field %0d ch%0d edge %0d): got %0d, expected %0d",
                     cur.name, cur.fld, cur.ch, cur.edge_n, act, cur.val);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      edge_n++;
      #1;
   endtask

   task automatic chk(string name, int fld, int ch, int val);
      q.push_back('{edge_n, name, fld, ch, val});
   endtask

   task automatic set_ch(int ch, bit e, bit ar, int t, int w, int o);
      en[ch]          = e;
      auto_reload[ch] = ar;
      timeout[ch*CNT_W +: CNT_W]     = t[CNT_W-1:0];
      warn_thresh[ch*CNT_W +: CNT_W] = w[CNT_W-1:0];
`ifdef WDT_WINDOW_EN
      window_open[ch*CNT_W +: CNT_W] = o[CNT_W-1:0];
`endif
   endtask

   initial begin
      rst = 1'b1; en = '0; kick = '0; ack = '0; auto_reload = '0;
      timeout = '0; warn_thresh = '0;
`ifdef WDT_WINDOW_EN
      window_open = '0;
`endif
      tick(); tick();
      for (int c = 0; c < NUM_CH; c++) begin
         chk("reset_cnt", F_CNT, c, 0);
         chk("reset_exp", F_EXP, c, 0);
         chk("reset_pulse", F_PUL, c, 0);
         chk("reset_warn", F_WARN, c, 0);
      end
      chk("reset_any", F_ANY, 0, 0);
      rst = 1'b0;

      // basic one-shot timeout, T=10
      set_ch(0, 1, 0, 10, 0, 0);
      tick(); chk("s1_start", F_CNT, 0, 0);
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("s1_cnt", F_CNT, 0, (k < 10) ? k : 10);
         chk("s1_pulse", F_PUL, 0, k == 10);
         chk("s1_exp", F_EXP, 0, k >= 10);
         chk("s1_any", F_ANY, 0, k >= 11);
         chk("s1_idle1", F_CNT, 1, 0);
      end
      if (count[0 +: CNT_W] !== 16'd10) begin
         miscompares++;
         $display("FAIL s1_hold_direct: count0=%0d", count[0 +: CNT_W]);
      end
      en[0] = 1'b0; ack[0] = 1'b1; tick();
      chk("s1_ack_exp", F_EXP, 0, 0);
      chk("s1_ack_cnt", F_CNT, 0, 0);
      chk("s1_any_lag", F_ANY, 0, 1);
      if (expired[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL s1_ack_direct: expired0=%0b", expired[0]);
      end
      ack[0] = 1'b0; tick();
      chk("s1_any_fall", F_ANY, 0, 0);

      // kick at count 5 with T=8, then kick colliding with expiry
      set_ch(0, 1, 0, 8, 0, 0);
      tick(); chk("s2_start", F_CNT, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         tick(); chk("s2_cnt", F_CNT, 0, k);
      end
      kick[0] = 1'b1; tick();
      chk("s2_kick_cnt", F_CNT, 0, 0);
      chk("s2_kick_vio", F_VIO, 0, 0);
      chk("s2_kick_pulse", F_PUL, 0, 0);
      kick[0] = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         tick();
         chk("s2_post_cnt", F_CNT, 0, (j < 8) ? j : 8);
         chk("s2_post_pulse", F_PUL, 0, j == 8);
         chk("s2_post_exp", F_EXP, 0, j == 8);
      end
      ack[0] = 1'b1; tick();
      chk("s2_ack_cnt", F_CNT, 0, 0);
      chk("s2_ack_exp", F_EXP, 0, 0);
      ack[0] = 1'b0;
      for (int j = 1; j <= 7; j++) begin
         tick(); chk("s2_run_cnt", F_CNT, 0, j);
      end
      kick[0] = 1'b1; tick();
      chk("s2_coll_cnt", F_CNT, 0, 0);
      chk("s2_coll_pulse", F_PUL, 0, 0);
      chk("s2_coll_exp", F_EXP, 0, 0);
      if (expire_pulse[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL s2_coll_direct: expire_pulse0=%0b", expire_pulse[0]);
      end
      kick[0] = 1'b0; tick();
      chk("s2_after_cnt", F_CNT, 0, 1);
      en[0] = 1'b0; tick();
      chk("s2_idle_cnt", F_CNT, 0, 0);

      // auto-reload with warning on channel 1, T=6 W=4, acks at cycles 8 and 12
      set_ch(1, 1, 1, 6, 4, 0);
      tick();
      chk("s3_start", F_CNT, 1, 0);
      chk("s3_start_warn", F_WARN, 1, 0);
      for (int c = 1; c <= 20; c++) begin
         ack[1] = (c == 8 || c == 12);
         tick();
         chk("s3_cnt", F_CNT, 1, c % 6);
         chk("s3_warn", F_WARN, 1, (c % 6) >= 4);
         chk("s3_pulse", F_PUL, 1, (c % 6) == 0);
         chk("s3_exp", F_EXP, 1, c >= 6 && !(c >= 8 && c < 12));
         chk("s3_any", F_ANY, 0, (c - 1) >= 6 && !((c - 1) >= 8 && (c - 1) < 12));
         chk("s3_idle0", F_CNT, 0, 0);
      end
      en[1] = 1'b0; ack[1] = 1'b1; tick();
      chk("s3_clear", F_EXP, 1, 0);
      ack[1] = 1'b0; auto_reload[1] = 1'b0;

      // reset mid-count while channel 1 is expired
      set_ch(0, 1, 0, 10, 0, 0);
      set_ch(1, 1, 0, 2, 0, 0);
      tick();
      for (int k = 1; k <= 3; k++) tick();
      chk("s4_pre_cnt0", F_CNT, 0, 3);
      chk("s4_pre_cnt1", F_CNT, 1, 2);
      chk("s4_pre_exp1", F_EXP, 1, 1);
      chk("s4_pre_any", F_ANY, 0, 1);
      rst = 1'b1;
      set_ch(0, 1, 0, 3, 0, 0);
      en[1] = 1'b0;
      tick();
      chk("s4_rst_cnt0", F_CNT, 0, 0);
      chk("s4_rst_cnt1", F_CNT, 1, 0);
      chk("s4_rst_exp1", F_EXP, 1, 0);
      chk("s4_rst_pulse1", F_PUL, 1, 0);
      chk("s4_rst_any", F_ANY, 0, 0);
      if (any_expired !== 1'b0) begin
         miscompares++;
         $display("FAIL s4_rst_direct: any_expired=%0b", any_expired);
      end
      rst = 1'b0; tick();
      chk("s4_restart", F_CNT, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("s4_cnt", F_CNT, 0, k);
         chk("s4_pulse", F_PUL, 0, k == 3);
      end
      kick[0] = 1'b1; tick();
      chk("s4_hold_cnt", F_CNT, 0, 3);
      chk("s4_hold_exp", F_EXP, 0, 1);
      chk("s4_hold_pulse", F_PUL, 0, 0);
      kick[0] = 1'b0; en[0] = 1'b0; tick();
      chk("s4_dis_cnt", F_CNT, 0, 0);
      chk("s4_dis_exp", F_EXP, 0, 1);
      tick();
      chk("s4_dis_exp2", F_EXP, 0, 1);
      chk("s4_dis_any", F_ANY, 0, 1);
      ack[0] = 1'b1; tick();
      chk("s4_ack_exp", F_EXP, 0, 0);
      ack[0] = 1'b0; tick();
      chk("s4_ack_any", F_ANY, 0, 0);

      // T=0 never expires
      set_ch(0, 1, 0, 0, 0, 0);
      tick();
      for (int k = 1; k <= 100; k++) begin
         tick();
         chk("s4_t0_cnt", F_CNT, 0, 0);
         chk("s4_t0_pulse", F_PUL, 0, 0);
         chk("s4_t0_exp", F_EXP, 0, 0);
      end
      if (count[0 +: CNT_W] !== 16'd0 || expired[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL s4_t0_direct: count0=%0d expired0=%0b", count[0 +: CNT_W], expired[0]);
      end
      en[0] = 1'b0; tick();

`ifdef WDT_WINDOW_EN
      // early kick at count 2 with O=5, then legal kick at count 7
      set_ch(0, 1, 0, 20, 0, 5);
      tick(); tick(); tick();
      chk("s5_cnt2", F_CNT, 0, 2);
      kick[0] = 1'b1; tick();
      chk("s5_vio", F_VIO, 0, 1);
      chk("s5_vio_pulse", F_PUL, 0, 1);
      chk("s5_vio_exp", F_EXP, 0, 1);
      kick[0] = 1'b0; tick();
      chk("s5_vio_clr", F_VIO, 0, 0);
      chk("s5_pulse_clr", F_PUL, 0, 0);
      chk("s5_exp_hold", F_EXP, 0, 1);
      ack[0] = 1'b1; tick();
      chk("s5_ack_cnt", F_CNT, 0, 0);
      chk("s5_ack_exp", F_EXP, 0, 0);
      ack[0] = 1'b0;
      for (int k = 1; k <= 7; k++) tick();
      chk("s5_cnt7", F_CNT, 0, 7);
      kick[0] = 1'b1; tick();
      chk("s5_ok_cnt", F_CNT, 0, 0);
      chk("s5_ok_vio", F_VIO, 0, 0);
      chk("s5_ok_pulse", F_PUL, 0, 0);
      chk("s5_ok_exp", F_EXP, 0, 0);
      kick[0] = 1'b0;
`endif

      tick(); tick();
      while (q.size() > 0) begin
         cur = q.pop_front();
         miscompares++;
         $display("FAIL %s (edge %0d): expectation never compared", cur.name, cur.edge_n);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
